// File: rtl/seg_pkg.sv
// seg_pkg: shared seven-segment definitions for the six-digit display path.
// Patterns are active-low. Bit 7 is the decimal point and bits 6..0 are
// segments g..a. The same definitions serve the scroll banner and the
// rotating-square generator.
package seg_pkg;

  typedef logic [7:0] seg_t;

  // Bit position of each segment inside a seg_t.
  typedef enum logic [2:0] {
    SEG_A  = 3'd0,
    SEG_B  = 3'd1,
    SEG_C  = 3'd2,
    SEG_D  = 3'd3,
    SEG_E  = 3'd4,
    SEG_F  = 3'd5,
    SEG_G  = 3'd6,
    SEG_DP = 3'd7
  } seg_bit_e;

  // Scroll direction as seen on the dir input.
  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

  localparam seg_t SEG_BLANK = 8'hFF;

  localparam seg_t GLYPH_0    = 8'hC0;
  localparam seg_t GLYPH_1    = 8'hF9;
  localparam seg_t GLYPH_2    = 8'hA4;
  localparam seg_t GLYPH_3    = 8'hB0;
  localparam seg_t GLYPH_4    = 8'h99;
  localparam seg_t GLYPH_5    = 8'h92;
  localparam seg_t GLYPH_6    = 8'h82;
  localparam seg_t GLYPH_7    = 8'hF8;
  localparam seg_t GLYPH_8    = 8'h80;
  localparam seg_t GLYPH_9    = 8'h90;
  localparam seg_t GLYPH_A    = 8'h88;
  localparam seg_t GLYPH_B    = 8'h83;
  localparam seg_t GLYPH_C    = 8'hC6;
  localparam seg_t GLYPH_D    = 8'hA1;
  localparam seg_t GLYPH_E    = 8'h86;
  localparam seg_t GLYPH_F    = 8'h8E;
  localparam seg_t GLYPH_H    = 8'h89;
  localparam seg_t GLYPH_L    = 8'hC7;
  localparam seg_t GLYPH_P    = 8'h8C;
  localparam seg_t GLYPH_DASH = 8'hBF;

  // Hex digit to glyph lookup.
  function automatic seg_t glyph_hex(input logic [3:0] v);
    seg_t g;
    case (v)
      4'h0:    g = GLYPH_0;
      4'h1:    g = GLYPH_1;
      4'h2:    g = GLYPH_2;
      4'h3:    g = GLYPH_3;
      4'h4:    g = GLYPH_4;
      4'h5:    g = GLYPH_5;
      4'h6:    g = GLYPH_6;
      4'h7:    g = GLYPH_7;
      4'h8:    g = GLYPH_8;
      4'h9:    g = GLYPH_9;
      4'hA:    g = GLYPH_A;
      4'hB:    g = GLYPH_B;
      4'hC:    g = GLYPH_C;
      4'hD:    g = GLYPH_D;
      4'hE:    g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/mod_m_tick.sv
// mod_m_tick: modulo-M enabled counter producing a one-cycle tick.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   en    - count enable; the count holds while low
//   clr   - synchronous clear of the count; suppresses tick
//   tick  - high for the cycle in which the count wraps from M-1 to 0
module mod_m_tick #(
  parameter int unsigned M = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = (M > 1) ? $clog2(M) : 1;
  localparam logic [W-1:0] LAST = W'(M - 1);

  logic [W-1:0] count;

  assign tick = en && !clr && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/scroll_banner.sv
// scroll_banner: writable circular message of segment patterns with a
// six-digit window scrolled at a programmable tick rate.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   en                - run/freeze the scroll tick counter
//   dir               - 1 scrolls left (pointer +1), 0 scrolls right (-1)
//   clr               - synchronous pointer/counter clear (message kept)
//   wr_en/wr_addr/wr_data - message entry write port
//   in0..in5          - registered digit patterns, in5 leftmost
//   wrap              - registered one-cycle pulse after a wrapping step
import seg_pkg::*;

module scroll_banner #(
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter int unsigned MSG_LEN  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       dir,
  input  logic       clr,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] in0,
  output logic [7:0] in1,
  output logic [7:0] in2,
  output logic [7:0] in3,
  output logic [7:0] in4,
  output logic [7:0] in5,
  output logic       wrap
);

  typedef logic [3:0] ptr_t;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned DIGITS  = 6;
  localparam logic [4:0]  LEN5    = 5'(MSG_LEN);
  localparam ptr_t        LAST    = ptr_t'(MSG_LEN - 1);

  // Storage is sized to the full 4-bit address space so wr_addr indexes it
  // directly; entries at or above MSG_LEN are never written and stay blank.
  seg_t msg [MAX_LEN];
  ptr_t ptr;
  ptr_t ptr_next;
  logic wrap_next;
  logic step;
  seg_t win [DIGITS];

  mod_m_tick #(
    .M(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .clr  (clr),
    .tick (step)
  );

  // (p + k) mod MSG_LEN with an explicit compare-and-wrap, since MSG_LEN
  // need not be a power of two.
  function automatic ptr_t add_mod(input ptr_t p, input logic [2:0] k);
    logic [4:0] s;
    s = {1'b0, p} + {2'b00, k};
    if (s >= LEN5) begin
      s = s - LEN5;
    end
    return s[3:0];
  endfunction

  always_comb begin
    ptr_next  = ptr;
    wrap_next = 1'b0;
    if (clr) begin
      ptr_next = '0;
    end else if (step) begin
      if (dir == DIR_LEFT) begin
        if (ptr == LAST) begin
          ptr_next  = '0;
          wrap_next = 1'b1;
        end else begin
          ptr_next = ptr + 1'b1;
        end
      end else begin
        if (ptr == '0) begin
          ptr_next  = LAST;
          wrap_next = 1'b1;
        end else begin
          ptr_next = ptr - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        msg[i] <= SEG_BLANK;
      end
    end else if (wr_en && ({1'b0, wr_addr} < LEN5)) begin
      msg[wr_addr] <= wr_data;
    end
  end

  // win[0] is the leftmost digit (in5).
  always_comb begin
    for (int unsigned k = 0; k < DIGITS; k++) begin
      win[k] = msg[add_mod(ptr, 3'(k))];
    end
  end

  // All six digits load on the same edge from the registered pointer and
  // message, so a pointer or message change shows one edge later, whole.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in5  <= SEG_BLANK;
      in4  <= SEG_BLANK;
      in3  <= SEG_BLANK;
      in2  <= SEG_BLANK;
      in1  <= SEG_BLANK;
      in0  <= SEG_BLANK;
      wrap <= 1'b0;
    end else begin
      in5  <= win[0];
      in4  <= win[1];
      in3  <= win[2];
      in2  <= win[3];
      in1  <= win[4];
      in0  <= win[5];
      wrap <= wrap_next;
    end
  end

endmodule
